// File: rtl/button_conditioner.sv
// Two-channel button front end: synchronize, debounce, emit one-cycle press pulses, plus long-press on start.
// Pulse follows a clean raw step by DEBOUNCE_CYCLES+3 clocks; outputs are fire-and-forget pulses with no backpressure.

module button_channel #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic res,
  input  logic raw,
  output logic pulse,
  output logic accept,
  output logic held
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DB_PRESS,
    PRESSED,
    DB_RELEASE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          meta;
  logic          sync;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state <= IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pulse <= accept;
    end
  end

  // The counter exits at CNT_LAST, so it never needs to wrap.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (sync) begin
          state_nxt = DB_PRESS;
          cnt_nxt   = '0;
        end
      end
      DB_PRESS: begin
        if (!sync) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = PRESSED;
          accept    = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      PRESSED: begin
        if (!sync) begin
          state_nxt = DB_RELEASE;
          cnt_nxt   = '0;
        end
      end
      DB_RELEASE: begin
        if (sync) begin
          state_nxt = PRESSED;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign held = (state == PRESSED) || (state == DB_RELEASE);

endmodule

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int LONG_CYCLES     = 2000000
) (
  input  logic clk,
  input  logic res,
  input  logic btn_start_raw,
  input  logic btn_lap_raw,
  output logic start_stop,
  output logic lap_time,
  output logic long_press
);

  localparam int LW = $clog2(LONG_CYCLES);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0] LONG_PRE  = LW'(LONG_CYCLES - 2);

  logic          start_accept;
  logic          start_held;
  logic          lap_accept;
  logic          lap_held;
  logic          unused_lap;
  logic [LW-1:0] lcnt;

  button_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
    .clk    (clk),
    .res    (res),
    .raw    (btn_start_raw),
    .pulse  (start_stop),
    .accept (start_accept),
    .held   (start_held)
  );

  button_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap (
    .clk    (clk),
    .res    (res),
    .raw    (btn_lap_raw),
    .pulse  (lap_time),
    .accept (lap_accept),
    .held   (lap_held)
  );

  assign unused_lap = lap_accept | lap_held;

  // Hold timer saturates at LONG_LAST, which also limits long_press to once per press.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      lcnt       <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (start_accept) begin
        lcnt <= '0;
      end else if (start_held && (lcnt != LONG_LAST)) begin
        lcnt       <= lcnt + LW'(1);
        long_press <= (lcnt == LONG_PRE);
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized and directed bench for button_conditioner against a run-length reference model.
module tb_button_conditioner;

  localparam int D = 4;
  localparam int L = 20;

  logic clk = 1'b0;
  logic res = 1'b0;
  logic btn_start_raw = 1'b0;
  logic btn_lap_raw = 1'b0;
  logic start_stop;
  logic lap_time;
  logic long_press;

  button_conditioner #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
    .clk           (clk),
    .res           (res),
    .btn_start_raw (btn_start_raw),
    .btn_lap_raw   (btn_lap_raw),
    .start_stop    (start_stop),
    .lap_time      (lap_time),
    .long_press    (long_press)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference: a level is accepted once D+1 consecutive synchronized samples disagree with it.
  logic [1:0] m_s1 = '0;
  logic [1:0] m_s2 = '0;
  logic [1:0] m_acc = '0;
  logic [1:0] m_ep = '0;
  int         m_run [2] = '{0, 0};
  int         m_held = 0;
  logic       m_was_held = 1'b0;
  logic       e_start = 1'b0;
  logic       e_lap = 1'b0;
  logic       e_long = 1'b0;

  initial begin
    forever begin
      @(posedge clk or posedge res);
      if (res) begin
        m_s1 = '0; m_s2 = '0; m_acc = '0;
        m_run[0] = 0; m_run[1] = 0; m_held = 0;
        e_start = 1'b0; e_lap = 1'b0; e_long = 1'b0;
      end else begin
        m_was_held = m_acc[0];
        m_ep = '0;
        for (int ch = 0; ch < 2; ch++) begin
          if (m_s2[ch] != m_acc[ch]) begin
            m_run[ch]++;
            if (m_run[ch] == D + 1) begin
              m_acc[ch] = m_s2[ch];
              m_run[ch] = 0;
              m_ep[ch]  = m_s2[ch];
            end
          end else begin
            m_run[ch] = 0;
          end
        end
        e_long = 1'b0;
        if (m_ep[0]) begin
          m_held = 0;
        end else if (m_was_held) begin
          m_held++;
          if (m_held == L - 1) e_long = 1'b1;
        end
        e_start = m_ep[0];
        e_lap   = m_ep[1];
        m_s2 = m_s1;
        m_s1 = {btn_lap_raw, btn_start_raw};
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("start_stop", int'(start_stop), int'(e_start));
      check("lap_time", int'(lap_time), int'(e_lap));
      check("long_press", int'(long_press), int'(e_long));
    end
  end

  int n_st, n_lp, n_lg, f_st, f_lp, f_lg;

  // Edge i samples sp[i-1]/lp[i-1]; records the first edge after which each output was high.
  task automatic run_edges(input int n, input logic [63:0] sp, input logic [63:0] lp);
    n_st = 0; n_lp = 0; n_lg = 0; f_st = 0; f_lp = 0; f_lg = 0;
    btn_start_raw = sp[0];
    btn_lap_raw   = lp[0];
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #3;
      btn_start_raw = sp[i];
      btn_lap_raw   = lp[i];
      @(negedge clk);
      if (start_stop) begin n_st++; if (f_st == 0) f_st = i; end
      if (lap_time)   begin n_lp++; if (f_lp == 0) f_lp = i; end
      if (long_press) begin n_lg++; if (f_lg == 0) f_lg = i; end
    end
  endtask

  task automatic do_reset(input logic st, input logic lp);
    @(posedge clk);
    #3;
    res = 1'b1;
    btn_start_raw = st;
    btn_lap_raw = lp;
    repeat (2) @(posedge clk);
    #3;
    res = 1'b0;
  endtask

  logic [63:0] ones;
  logic [63:0] zeros;
  logic [63:0] pat;
  logic        lvl [2];
  int          rem [2];

  initial begin
    ones  = '1;
    zeros = '0;
    #1 res = 1'b1;
    #1;
    check("rst_start", int'(start_stop), 0);
    check("rst_lap", int'(lap_time), 0);
    check("rst_long", int'(long_press), 0);
    repeat (2) @(posedge clk);
    #3 res = 1'b0;

    // clean press held 30 clocks
    run_edges(30, ones, zeros);
    check("clean_start_edge", f_st, 7);
    check("clean_start_cnt", n_st, 1);
    check("clean_long_edge", f_lg, 26);
    check("clean_long_cnt", n_lg, 1);
    check("clean_lap_cnt", n_lp, 0);

    // lap bounce 1,0,1,0 in pairs then held
    do_reset(1'b0, 1'b0);
    pat = ones;
    pat[2] = 1'b0; pat[3] = 1'b0; pat[6] = 1'b0; pat[7] = 1'b0;
    run_edges(24, zeros, pat);
    check("bounce_lap_edge", f_lp, 15);
    check("bounce_lap_cnt", n_lp, 1);
    check("bounce_start_cnt", n_st, 0);

    // release glitch of two clocks while held
    do_reset(1'b0, 1'b0);
    pat = ones;
    pat[11] = 1'b0; pat[12] = 1'b0;
    run_edges(32, pat, zeros);
    check("relb_start_cnt", n_st, 1);
    check("relb_start_edge", f_st, 7);
    check("relb_long_edge", f_lg, 26);
    check("relb_long_cnt", n_lg, 1);

    // both channels rise together
    do_reset(1'b0, 1'b0);
    run_edges(10, ones, ones);
    check("simul_start_edge", f_st, 7);
    check("simul_lap_edge", f_lp, 7);
    check("simul_start_cnt", n_st, 1);
    check("simul_lap_cnt", n_lp, 1);

    // reset mid-debounce with button held through deassertion
    do_reset(1'b0, 1'b0);
    run_edges(4, ones, zeros);
    #2 res = 1'b1;
    #1;
    check("mid_rst_start", int'(start_stop), 0);
    check("mid_rst_long", int'(long_press), 0);
    repeat (2) @(posedge clk);
    #3 res = 1'b0;
    run_edges(12, ones, zeros);
    check("post_rst_start_edge", f_st, 7);
    check("post_rst_start_cnt", n_st, 1);

    // reset landing on a live pulse clears it without a clock
    do_reset(1'b0, 1'b0);
    run_edges(7, ones, zeros);
    check("pulse_hi", int'(start_stop), 1);
    #2 res = 1'b1;
    #1;
    check("async_clr", int'(start_stop), 0);
    @(posedge clk);
    #3 res = 1'b0;

    // random bouncing levels with occasional resets
    do_reset(1'b0, 1'b0);
    lvl[0] = 1'b0; lvl[1] = 1'b0; rem[0] = 0; rem[1] = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #3;
      if (res) res = 1'b0;
      else if ($urandom_range(0, 499) == 0) res = 1'b1;
      for (int ch = 0; ch < 2; ch++) begin
        if (rem[ch] == 0) begin
          lvl[ch] = ~lvl[ch];
          rem[ch] = ($urandom_range(0, 9) < 7) ? int'($urandom_range(1, 3)) : int'($urandom_range(5, 40));
        end else begin
          rem[ch]--;
        end
      end
      btn_start_raw = lvl[0];
      btn_lap_raw   = lvl[1];
    end
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20000: number of consecutive stable synchronized samples required to accept a press or release; legal range >= 1.
REQ-002 Parameter LONG_CYCLES, default 2000000: held-press duration on the start channel, counted in clocks from press acceptance, that triggers long_press; legal range > DEBOUNCE_CYCLES.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 res  input  1  reset, asynchronous, active-high.
REQ-005 btn_start_raw  input  1  raw, asynchronous, bouncing start/stop button level; 1 = pressed.
REQ-006 btn_lap_raw  input  1  raw, asynchronous, bouncing lap button level; 1 = pressed.
REQ-007 start_stop  output  1  registered single-cycle pulse, one per accepted start button press; feeds the controller start_stop input.
REQ-008 lap_time  output  1  registered single-cycle pulse, one per accepted lap button press; feeds the controller lap_time input.
REQ-009 long_press  output  1  registered single-cycle pulse when the start button has been held LONG_CYCLES clocks past acceptance.

Function
REQ-010 Each raw input SHALL pass through its own two-flop synchronizer; only the second-stage output (sync) is used downstream.
REQ-011 Start and lap channels SHALL be identical, independent instances of one FSM with a private debounce counter; long_press logic exists on the start channel only.
REQ-012 FSM states SHALL be IDLE, DB_PRESS, PRESSED, DB_RELEASE.
REQ-013 IDLE: sync=1 -> DB_PRESS with counter cleared to 0; otherwise remain.
REQ-014 DB_PRESS: sync=0 -> IDLE (bounce, no pulse); sync=1 and counter = DEBOUNCE_CYCLES-1 -> PRESSED and assert channel pulse; otherwise counter +1.
REQ-015 PRESSED: sync=0 -> DB_RELEASE with counter cleared to 0; otherwise remain.
REQ-016 DB_RELEASE: sync=1 -> PRESSED with no new pulse; sync=0 and counter = DEBOUNCE_CYCLES-1 -> IDLE; otherwise counter +1.
REQ-017 Latency: for a clean raw step sampled high first at edge 1, channel pulse SHALL be high for exactly the one cycle following edge DEBOUNCE_CYCLES+3.
REQ-018 Each accepted press SHALL yield exactly one pulse, never high on two consecutive cycles; held buttons produce no further press pulses.
REQ-019 Long counter SHALL clear to 0 on entering PRESSED from DB_PRESS, increment each clock in PRESSED or DB_RELEASE, and saturate (no wrap).
REQ-020 long_press SHALL pulse for one cycle when the long counter reaches LONG_CYCLES-1, at most once per accepted press; start_stop pulse is still issued at acceptance.
REQ-021 Counter widths SHALL be sized to hold DEBOUNCE_CYCLES-1 and LONG_CYCLES-1 respectively; no counter ever wraps.
REQ-022 Simultaneous events: both channels may pulse in the same cycle; no priority or suppression between channels.

Reset
REQ-023 While res=1 all synchronizer flops, counters and outputs SHALL be 0 and both FSMs in IDLE, taking effect immediately without a clock.
REQ-024 Reset asserted mid-debounce or mid-hold SHALL discard all progress; no pulse is emitted during or because of reset.
REQ-025 A button held through reset deassertion SHALL be treated as a new press: one pulse after the REQ-017 latency measured from the first edge after deassertion.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20)
REQ-026 Clean press: btn_start_raw 0->1 held 30 clocks -> start_stop high exactly one cycle after edge 7, long_press one cycle pulse 19 clocks after that pulse's edge, lap_time stays 0.
REQ-027 Bounce: btn_lap_raw toggles 1,0,1,0 each 2 clocks then held 1 -> exactly one lap_time pulse, first after the stable-high run reaches 4 synchronized samples.
REQ-028 Release bounce: held button drops to 0 for 2 clocks then returns to 1 -> no second pulse, state returns to PRESSED, long_press timing unaffected.
REQ-029 Simultaneous: both raw inputs rise on the same edge -> start_stop and lap_time pulse in the same cycle.
REQ-030 Reset: res pulsed asynchronously mid-DB_PRESS with button held -> outputs 0 immediately, single start_stop pulse 7 edges after first post-reset edge.
